vls_wb_queue: RTL and testbench
===============================

// Module: vls_wb_queue
// PURPOSE
//   Load-writeback stage directly downstream of vls. Holds the destination vector register (vd)
//   of every issued vector load per port (a/b), pairs it with the in-order load response, and
//   drains completed loads to the vector register file write port, one per cycle, valid/ready.
//   Two ports share one write port via round-robin arbitration.
// PARAMETERS
//   DEPTH   4   entries per port queue; power of two, >= 2
//   VREG_W  4   width of vd index
//   DATA_W  32  bits per element
//   LANES   4   elements per load response / writeback
// PORTS
//   CLK            in   1               clock, rising edge
//   nRST           in   1               asynchronous active-low reset
//   issue_valid_a  in   1               vls issues a load on port a; push issue_vd_a
//   issue_vd_a     in   VREG_W          destination register, port a
//   issue_ready_a  out  1               port a queue can accept (count_a < DEPTH)
//   issue_valid_b / issue_vd_b / issue_ready_b  same for port b
//   resp_valid_a   in   1               load data for oldest unfilled port-a entry
//   resp_data_a    in   LANES*DATA_W    load data, lane 0 in LSBs
//   resp_valid_b / resp_data_b          same for port b
//   wb_valid       out  1               writeback request to register file
//   wb_ready       in   1               register file accepts this cycle
//   wb_vd          out  VREG_W          destination register
//   wb_data        out  LANES*DATA_W    data to write
//   wb_src         out  1               0 = from port a, 1 = from port b
//   resp_err       out  1               sticky: a response arrived with no unfilled entry
// BEHAVIOUR
// - Reset (async, nRST=0): all pointers/counts 0, all data_valid flags 0, wb_valid=0, wb_vd=0,
//   wb_data=0, wb_src=0, resp_err=0, round-robin priority = port a. Reset mid-operation discards
//   all pending entries and any held writeback; no writeback is emitted after reset release
//   until a new issue+response completes.
// - Per port: circular queue, pointers alloc/fill/head (log2 DEPTH bits, wrap DEPTH-1 -> 0),
//   count 0..DEPTH. Entry = {vd, data, data_valid}.
// - Issue: accepted when issue_valid && issue_ready; writes vd at alloc, data_valid=0, alloc++.
//   issue_ready is from the start-of-cycle count: a pop in the same cycle does NOT free space
//   for a push when full.
// - Response: fills entry at fill only if fill != alloc as of start of cycle (entry issued in an
//   earlier cycle); sets data_valid, fill++. Otherwise response dropped, resp_err <= 1 (sticky
//   until reset). A response in the same cycle as the issue of its entry is an error.
// - Output register: load when !wb_valid || wb_ready. Candidates = port heads with count>0 and
//   data_valid=1. One candidate -> it wins. Both -> priority port wins, priority then flips to
//   the other port. Winner popped (head++, count--, data_valid cleared) on the same edge.
//   No candidate and output free -> wb_valid <= 0.
// - wb_valid && !wb_ready: wb_vd/wb_data/wb_src held stable, no pop.
// - Latency: response sampled at edge E, queue empty ahead, output free -> wb_valid high after
//   edge E+1. Throughput 1 writeback/cycle with wb_ready=1.
// - Per-port order preserved; issue, response and pop may all occur in one cycle on one port.
// TESTING
//  1 Reset: nRST=0 mid-traffic -> wb_valid=0, issue_ready_a/b=1, resp_err=0, nothing drains later.
//  2 Single load: issue_vd_a=1; next cycle resp_data_a lanes=32'd10 -> wb_valid after E+1,
//    wb_vd=1, wb_src=0, all lanes 10; wb_ready=1 -> one write only.
//  3 Contention: both heads ready same cycle, vd_a=1, vd_b=2 -> vd 1 then vd 2; repeat ->
//    b's entry wins first (priority flipped).
//  4 Backpressure: wb_ready=0 5 cycles -> outputs stable; 4 more issues on a -> issue_ready_a=0
//    at count 4; issue on full with same-cycle pop rejected.
//  5 Orphan response: resp_valid_b with empty b queue -> resp_err=1 sticky, no wb_valid.
//  6 Pipelined stream: 8 loads on a with resp 1 cycle after each issue, wb_ready=1 ->
//    8 writebacks back-to-back in issue order, no gap after the first.

Source files
------------

// File: rtl/vls_wb_queue.sv
// Load-writeback queue: pairs each issued vector-load destination with its in-order response
// and drains completed loads from two ports to one register-file write port, round-robin.

module vls_wb_port #(
    parameter int DEPTH  = 4,
    parameter int VREG_W = 4,
    parameter int DW     = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              issue_valid_i,
    input  logic [VREG_W-1:0] issue_vd_i,
    output logic              issue_ready_o,
    input  logic              resp_valid_i,
    input  logic [DW-1:0]     resp_data_i,
    input  logic              pop_i,
    output logic              head_valid_o,
    output logic [VREG_W-1:0] head_vd_o,
    output logic [DW-1:0]     head_data_o,
    output logic              orphan_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0]    PTR_ONE   = PW'(1'b1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0]    CNT_DEPTH = CW'(DEPTH);
    localparam logic [DEPTH-1:0] ONE_HOT   = DEPTH'(1'b1);

    logic [PW-1:0]                  alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
    logic [CW-1:0]                  count_q, count_d, pend_q, pend_d;
    logic [DEPTH-1:0]               dv_q, dv_d, fill_oh_s, clr_oh_s;
    logic [DEPTH-1:0][VREG_W-1:0]   vd_q;
    logic [DEPTH-1:0][DW-1:0]       data_q;
    logic                           push_s, fill_s;

    // pend counts issued-but-unfilled entries, so a full queue of unfilled loads still accepts data
    assign issue_ready_o = (count_q != CNT_DEPTH);
    assign push_s        = issue_valid_i && issue_ready_o;
    assign fill_s        = resp_valid_i && (pend_q != {CW{1'b0}});
    assign orphan_o      = resp_valid_i && (pend_q == {CW{1'b0}});
    assign head_valid_o  = (count_q != {CW{1'b0}}) && dv_q[head_q];
    assign head_vd_o     = vd_q[head_q];
    assign head_data_o   = data_q[head_q];

    // Next-state for pointers, occupancy counts and per-entry data-valid flags
    always_comb begin
        alloc_d   = push_s ? (alloc_q + PTR_ONE) : alloc_q;
        fill_d    = fill_s ? (fill_q + PTR_ONE) : fill_q;
        head_d    = pop_i ? (head_q + PTR_ONE) : head_q;
        fill_oh_s = fill_s ? (ONE_HOT << fill_q) : {DEPTH{1'b0}};
        clr_oh_s  = (push_s ? (ONE_HOT << alloc_q) : {DEPTH{1'b0}})
                  | (pop_i ? (ONE_HOT << head_q) : {DEPTH{1'b0}});
        dv_d      = (dv_q & ~clr_oh_s) | fill_oh_s;
        case ({push_s, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        case ({push_s, fill_s})
            2'b10:   pend_d = pend_q + CNT_ONE;
            2'b01:   pend_d = pend_q - CNT_ONE;
            default: pend_d = pend_q;
        endcase
    end

    // Queue control state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_q <= {PW{1'b0}};
            fill_q  <= {PW{1'b0}};
            head_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            pend_q  <= {CW{1'b0}};
            dv_q    <= {DEPTH{1'b0}};
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            head_q  <= head_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            dv_q    <= dv_d;
        end
    end

    // Entry payload storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vd_q   <= {(DEPTH*VREG_W){1'b0}};
            data_q <= {(DEPTH*DW){1'b0}};
        end else begin
            if (push_s) begin
                vd_q[alloc_q] <= issue_vd_i;
            end
            if (fill_s) begin
                data_q[fill_q] <= resp_data_i;
            end
        end
    end
endmodule

module vls_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int VREG_W = 4,
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    issue_valid_a,
    input  logic [VREG_W-1:0]       issue_vd_a,
    output logic                    issue_ready_a,
    input  logic                    issue_valid_b,
    input  logic [VREG_W-1:0]       issue_vd_b,
    output logic                    issue_ready_b,
    input  logic                    resp_valid_a,
    input  logic [LANES*DATA_W-1:0] resp_data_a,
    input  logic                    resp_valid_b,
    input  logic [LANES*DATA_W-1:0] resp_data_b,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [VREG_W-1:0]       wb_vd,
    output logic [LANES*DATA_W-1:0] wb_data,
    output logic                    wb_src,
    output logic                    resp_err
);
    localparam int DW = LANES * DATA_W;

    logic              cand_a_s, cand_b_s, pop_a_s, pop_b_s, orphan_a_s, orphan_b_s, load_s;
    logic [VREG_W-1:0] head_vd_a_s, head_vd_b_s;
    logic [DW-1:0]     head_data_a_s, head_data_b_s;
    logic              wb_valid_q, wb_valid_d, wb_src_q, wb_src_d, prio_q, prio_d;
    logic              resp_err_q, resp_err_d;
    logic [VREG_W-1:0] wb_vd_q, wb_vd_d;
    logic [DW-1:0]     wb_data_q, wb_data_d;

    vls_wb_port #(.DEPTH(DEPTH), .VREG_W(VREG_W), .DW(DW)) u_port_a (
        .clk_i(CLK), .rst_ni(nRST),
        .issue_valid_i(issue_valid_a), .issue_vd_i(issue_vd_a), .issue_ready_o(issue_ready_a),
        .resp_valid_i(resp_valid_a), .resp_data_i(resp_data_a), .pop_i(pop_a_s),
        .head_valid_o(cand_a_s), .head_vd_o(head_vd_a_s), .head_data_o(head_data_a_s),
        .orphan_o(orphan_a_s)
    );

    vls_wb_port #(.DEPTH(DEPTH), .VREG_W(VREG_W), .DW(DW)) u_port_b (
        .clk_i(CLK), .rst_ni(nRST),
        .issue_valid_i(issue_valid_b), .issue_vd_i(issue_vd_b), .issue_ready_o(issue_ready_b),
        .resp_valid_i(resp_valid_b), .resp_data_i(resp_data_b), .pop_i(pop_b_s),
        .head_valid_o(cand_b_s), .head_vd_o(head_vd_b_s), .head_data_o(head_data_b_s),
        .orphan_o(orphan_b_s)
    );

    // Writeback arbitration: prio_q=1 means port b wins the next tie; it flips only on a tie
    always_comb begin
        load_s     = !wb_valid_q || wb_ready;
        pop_a_s    = 1'b0;
        pop_b_s    = 1'b0;
        prio_d     = prio_q;
        wb_valid_d = wb_valid_q;
        wb_vd_d    = wb_vd_q;
        wb_data_d  = wb_data_q;
        wb_src_d   = wb_src_q;
        resp_err_d = resp_err_q | orphan_a_s | orphan_b_s;
        if (load_s) begin
            case ({cand_a_s, cand_b_s})
                2'b11: begin
                    if (prio_q) begin
                        pop_b_s = 1'b1;
                        prio_d  = 1'b0;
                    end else begin
                        pop_a_s = 1'b1;
                        prio_d  = 1'b1;
                    end
                end
                2'b10:   pop_a_s = 1'b1;
                2'b01:   pop_b_s = 1'b1;
                default: pop_a_s = 1'b0;
            endcase
            wb_valid_d = pop_a_s || pop_b_s;
            if (pop_b_s) begin
                wb_vd_d   = head_vd_b_s;
                wb_data_d = head_data_b_s;
                wb_src_d  = 1'b1;
            end else if (pop_a_s) begin
                wb_vd_d   = head_vd_a_s;
                wb_data_d = head_data_a_s;
                wb_src_d  = 1'b0;
            end else begin
                wb_vd_d   = wb_vd_q;
                wb_data_d = wb_data_q;
                wb_src_d  = wb_src_q;
            end
        end else begin
            wb_valid_d = wb_valid_q;
        end
    end

    // Output register, arbitration priority and sticky error flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_valid_q <= 1'b0;
            wb_vd_q    <= {VREG_W{1'b0}};
            wb_data_q  <= {DW{1'b0}};
            wb_src_q   <= 1'b0;
            prio_q     <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_vd_q    <= wb_vd_d;
            wb_data_q  <= wb_data_d;
            wb_src_q   <= wb_src_d;
            prio_q     <= prio_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_vd    = wb_vd_q;
    assign wb_data  = wb_data_q;
    assign wb_src   = wb_src_q;
    assign resp_err = resp_err_q;
endmodule

// File: tb/tb_vls_wb_queue.sv
// Scoreboard bench for vls_wb_queue: stimulus pushes expected writebacks, a negedge monitor
// pops and compares them on every accepted writeback.

module tb_vls_wb_queue;
    typedef struct {
        logic         src;
        logic [3:0]   vd;
        logic [127:0] data;
    } exp_t;

    logic         CLK = 1'b0;
    logic         nRST = 1'b1;
    logic         issue_valid_a = 1'b0, issue_valid_b = 1'b0;
    logic [3:0]   issue_vd_a = 4'd0, issue_vd_b = 4'd0;
    logic         issue_ready_a, issue_ready_b;
    logic         resp_valid_a = 1'b0, resp_valid_b = 1'b0;
    logic [127:0] resp_data_a = 128'd0, resp_data_b = 128'd0;
    logic         wb_valid, wb_ready = 1'b1, wb_src, resp_err;
    logic [3:0]   wb_vd;
    logic [127:0] wb_data;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   hs_cyc[$];
    exp_t mon_e;
    logic [3:0]   held_vd;
    logic [127:0] held_data;
    logic         held_src;
    int           hs_base;

    vls_wb_queue dut (
        .CLK(CLK), .nRST(nRST),
        .issue_valid_a(issue_valid_a), .issue_vd_a(issue_vd_a), .issue_ready_a(issue_ready_a),
        .issue_valid_b(issue_valid_b), .issue_vd_b(issue_vd_b), .issue_ready_b(issue_ready_b),
        .resp_valid_a(resp_valid_a), .resp_data_a(resp_data_a),
        .resp_valid_b(resp_valid_b), .resp_data_b(resp_data_b),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_vd(wb_vd), .wb_data(wb_data),
        .wb_src(wb_src), .resp_err(resp_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [127:0] lanes(input logic [31:0] v);
        return {4{v}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_wb(input logic src, input logic [3:0] vd, input logic [127:0] data);
        exp_t e;
        e.src = src; e.vd = vd; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check(name, 128'(exp_q.size()), 128'd0);
        tick();
    endtask

    // Scoreboard monitor: every accepted writeback must match the oldest expected entry
    always @(negedge CLK) begin
        if (nRST && wb_valid && wb_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got vd %0d src %0d expected no writeback", wb_vd, wb_src);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_src", 128'(wb_src), 128'(mon_e.src));
                check("wb_vd", 128'(wb_vd), 128'(mon_e.vd));
                check("wb_data", wb_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1 nRST = 1'b0;
        #2;
        check("rst_wb_valid", 128'(wb_valid), 128'd0);
        check("rst_wb_vd", 128'(wb_vd), 128'd0);
        check("rst_wb_data", wb_data, 128'd0);
        check("rst_ready_a", 128'(issue_ready_a), 128'd1);
        check("rst_ready_b", 128'(issue_ready_b), 128'd1);
        check("rst_resp_err", 128'(resp_err), 128'd0);
        tick(); tick();
        nRST = 1'b1;
        tick();

        // Single load with latency check
        issue_valid_a = 1'b1; issue_vd_a = 4'd1;
        tick();
        issue_valid_a = 1'b0;
        resp_valid_a = 1'b1; resp_data_a = lanes(32'd10);
        expect_wb(1'b0, 4'd1, lanes(32'd10));
        tick();
        resp_valid_a = 1'b0;
        check("lat_not_yet", 128'(wb_valid), 128'd0);
        tick();
        check("lat_valid", 128'(wb_valid), 128'd1);
        tick();
        check("single_once", 128'(wb_valid), 128'd0);
        drain("drain_single");

        // Contention: a first, then b wins the next tie
        issue_valid_a = 1'b1; issue_vd_a = 4'd1; issue_valid_b = 1'b1; issue_vd_b = 4'd2;
        tick();
        issue_valid_a = 1'b0; issue_valid_b = 1'b0;
        resp_valid_a = 1'b1; resp_data_a = lanes(32'h11);
        resp_valid_b = 1'b1; resp_data_b = lanes(32'h22);
        expect_wb(1'b0, 4'd1, lanes(32'h11));
        expect_wb(1'b1, 4'd2, lanes(32'h22));
        tick();
        resp_valid_a = 1'b0; resp_valid_b = 1'b0;
        drain("drain_contend1");
        issue_valid_a = 1'b1; issue_vd_a = 4'd1; issue_valid_b = 1'b1; issue_vd_b = 4'd2;
        tick();
        issue_valid_a = 1'b0; issue_valid_b = 1'b0;
        resp_valid_a = 1'b1; resp_data_a = lanes(32'h33);
        resp_valid_b = 1'b1; resp_data_b = lanes(32'h44);
        expect_wb(1'b1, 4'd2, lanes(32'h44));
        expect_wb(1'b0, 4'd1, lanes(32'h33));
        tick();
        resp_valid_a = 1'b0; resp_valid_b = 1'b0;
        drain("drain_contend2");

        // Backpressure, full queue, rejected issue on full with same-cycle pop
        wb_ready = 1'b0;
        issue_valid_a = 1'b1; issue_vd_a = 4'd3;
        tick();
        issue_valid_a = 1'b0;
        resp_valid_a = 1'b1; resp_data_a = lanes(32'h55);
        expect_wb(1'b0, 4'd3, lanes(32'h55));
        tick();
        resp_valid_a = 1'b0;
        tick();
        check("bp_valid", 128'(wb_valid), 128'd1);
        held_vd = wb_vd; held_data = wb_data; held_src = wb_src;
        for (int i = 0; i < 4; i++) begin
            issue_valid_a = 1'b1; issue_vd_a = 4'(4 + i);
            tick();
            check("bp_hold_vd", 128'(wb_vd), 128'(held_vd));
            check("bp_hold_data", wb_data, held_data);
            check("bp_hold_src", 128'(wb_src), 128'(held_src));
            check("bp_ready_a", 128'(issue_ready_a), (i < 3) ? 128'd1 : 128'd0);
        end
        issue_valid_a = 1'b0;
        tick();
        check("bp_hold_vd5", 128'(wb_vd), 128'(held_vd));
        check("bp_hold_valid5", 128'(wb_valid), 128'd1);
        for (int i = 0; i < 4; i++) begin
            resp_valid_a = 1'b1; resp_data_a = lanes(32'h60 + 32'(i));
            expect_wb(1'b0, 4'(4 + i), lanes(32'h60 + 32'(i)));
            tick();
        end
        resp_valid_a = 1'b0;
        check("full_ready_a", 128'(issue_ready_a), 128'd0);
        wb_ready = 1'b1;
        issue_valid_a = 1'b1; issue_vd_a = 4'd8;
        tick();
        issue_valid_a = 1'b0;
        check("after_pop_ready_a", 128'(issue_ready_a), 128'd1);
        drain("drain_bp");
        issue_valid_a = 1'b1; issue_vd_a = 4'd9;
        tick();
        issue_valid_a = 1'b0;
        resp_valid_a = 1'b1; resp_data_a = lanes(32'h99);
        expect_wb(1'b0, 4'd9, lanes(32'h99));
        tick();
        resp_valid_a = 1'b0;
        drain("drain_reject");

        // Orphan response on empty port b
        resp_valid_b = 1'b1; resp_data_b = lanes(32'hdead);
        tick();
        resp_valid_b = 1'b0;
        check("orphan_err", 128'(resp_err), 128'd1);
        check("orphan_no_wb", 128'(wb_valid), 128'd0);
        repeat (3) tick();
        check("orphan_sticky", 128'(resp_err), 128'd1);
        check("orphan_no_wb_late", 128'(wb_valid), 128'd0);

        // Pipelined stream of 8 loads on port a
        hs_base = hs_cyc.size();
        for (int i = 0; i <= 8; i++) begin
            issue_valid_a = (i < 8);
            issue_vd_a = 4'(i);
            resp_valid_a = (i > 0);
            resp_data_a = lanes(32'h100 + 32'(i) - 32'd1);
            if (i > 0) expect_wb(1'b0, 4'(i - 1), lanes(32'h100 + 32'(i) - 32'd1));
            tick();
        end
        issue_valid_a = 1'b0; resp_valid_a = 1'b0;
        drain("drain_stream");
        check("stream_count", 128'(hs_cyc.size() - hs_base), 128'd8);
        if (hs_cyc.size() - hs_base == 8)
            check("stream_no_gap", 128'(hs_cyc[hs_base + 7] - hs_cyc[hs_base]), 128'd7);

        // Reset mid-traffic with a held writeback and a pending entry
        wb_ready = 1'b0;
        issue_valid_a = 1'b1; issue_vd_a = 4'd10; issue_valid_b = 1'b1; issue_vd_b = 4'd11;
        tick();
        issue_valid_a = 1'b0; issue_valid_b = 1'b0;
        resp_valid_a = 1'b1; resp_data_a = lanes(32'haa);
        resp_valid_b = 1'b1; resp_data_b = lanes(32'hbb);
        tick();
        resp_valid_a = 1'b0; resp_valid_b = 1'b0;
        tick();
        check("pre_rst_valid", 128'(wb_valid), 128'd1);
        #2 nRST = 1'b0;
        #1;
        check("mid_rst_valid", 128'(wb_valid), 128'd0);
        check("mid_rst_ready_a", 128'(issue_ready_a), 128'd1);
        check("mid_rst_ready_b", 128'(issue_ready_b), 128'd1);
        check("mid_rst_err", 128'(resp_err), 128'd0);
        wb_ready = 1'b1;
        tick(); tick();
        nRST = 1'b1;
        repeat (6) tick();
        check("post_rst_idle", 128'(wb_valid), 128'd0);

        // Normal operation after reset
        issue_valid_b = 1'b1; issue_vd_b = 4'd12;
        tick();
        issue_valid_b = 1'b0;
        resp_valid_b = 1'b1; resp_data_b = lanes(32'h77);
        expect_wb(1'b1, 4'd12, lanes(32'h77));
        tick();
        resp_valid_b = 1'b0;
        drain("drain_post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
